axi_rd_burst_splitter: RTL and testbench

//  Read-channel stage between the kernel AXI4 master (AxiTop m_axi_ar*/r*) and the DMA PCIS slave's

---
 rtl/axi_split_pkg.sv | 19 +
 rtl/axi_split_flag_fifo.sv | 58 +++++
 rtl/axi_rd_burst_splitter.sv | 160 ++++++++++++++++
 tb/tb_axi_rd_burst_splitter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_split_pkg.sv
// Shared constants, FSM state type and sub-burst length helper for the AXI read burst splitter.
package axi_split_pkg;

    localparam int BEAT_BYTES     = 64;
    localparam int BOUNDARY_BYTES = 4096;

    typedef enum logic [0:0] {
        IDLE,
        ISSUE
    } split_state_e;

    function automatic logic [12:0] min3(input logic [12:0] a, input logic [12:0] b,
                                         input logic [12:0] c);
        logic [12:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/axi_split_flag_fifo.sv
// One-bit flag FIFO holding the "last sub-burst of the parent burst" marker per issued sub-burst.
module axi_split_flag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a push is still taken when full.
    assign rd_ok = pop && !empty;
    assign wr_ok = push && (!full || rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_burst_splitter.sv
// Splits AXI4 read bursts at 4 KiB boundaries and MAX_BEATS, re-forming one rlast per parent burst.
// Optional AXI_RD_SPLIT_STATS_EN adds saturating burst, sub-burst and FIFO-stall counters.
module axi_rd_burst_splitter
    import axi_split_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = BEAT_BYTES * 8,
    parameter int MAX_BEATS   = 64,
    parameter int OUTSTANDING = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast
`ifdef AXI_RD_SPLIT_STATS_EN
    ,
    output logic [31:0]       stat_bursts,
    output logic [31:0]       stat_subbursts,
    output logic [31:0]       stat_fifo_full_cycles
`endif
);
    localparam int BB  = DATA_W / 8;
    localparam int BSH = $clog2(BB);

    split_state_e      state;
    split_state_e      nxt;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        rem;
    logic [7:0]        len;
    logic              ar_rdy;

    logic              s_hs;
    logic              m_hs;
    logic [8:0]        sub;
    logic              last_sub;
    logic [ADDR_W-1:0] src_addr;
    logic [8:0]        src_rem;
    logic [12:0]       bnd_beats;
    logic [8:0]        nsub;

    logic              fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              unused_arsize;

    assign unused_arsize = ^s_axi_arsize;

    assign sub      = {1'b0, len} + 9'd1;
    assign last_sub = (rem == sub);
    assign s_hs     = s_axi_arvalid && ar_rdy;
    assign m_hs     = m_axi_arvalid && m_axi_arready;

    assign s_axi_arready = ar_rdy;
    assign m_axi_arvalid = (state == ISSUE) && !fifo_full;
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = len;
    assign m_axi_arsize  = 3'(BSH);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (s_hs) nxt = ISSUE;
            ISSUE:   if (m_hs && last_sub) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The length register is loaded one step ahead, from the new burst in IDLE or
    // from the post-handshake address/remainder in ISSUE, so m_arlen comes from a flop.
    always_comb begin
        src_addr = addr + (ADDR_W'(sub) << BSH);
        src_rem  = rem - sub;
        if (state == IDLE) begin
            src_addr = s_axi_araddr & ~ADDR_W'(BB - 1);
            src_rem  = {1'b0, s_axi_arlen} + 9'd1;
        end
        bnd_beats = (13'(BOUNDARY_BYTES) - {1'b0, src_addr[11:0]}) >> BSH;
        nsub      = 9'(min3(13'(src_rem), bnd_beats, 13'(MAX_BEATS)));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            ar_rdy <= 1'b0;
            addr   <= '0;
            rem    <= '0;
            len    <= '0;
        end else begin
            state  <= nxt;
            ar_rdy <= (nxt == IDLE);
            if (s_hs || (m_hs && !last_sub)) begin
                addr <= src_addr;
                rem  <= src_rem;
                len  <= 8'(nsub - 9'd1);
            end
        end
    end

    assign fifo_pop = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    axi_split_flag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_flags (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (m_hs),
        .din   (last_sub),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast && !fifo_empty && fifo_head;

    // Read data with no sub-burst outstanding means the downstream broke the protocol.
    r_without_ar: assert property (@(posedge aclk) disable iff (!aresetn)
        !(m_axi_rvalid && fifo_empty));

`ifdef AXI_RD_SPLIT_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_bursts           <= '0;
            stat_subbursts        <= '0;
            stat_fifo_full_cycles <= '0;
        end else begin
            if (s_hs && stat_bursts != '1)
                stat_bursts <= stat_bursts + 32'd1;
            if (m_hs && stat_subbursts != '1)
                stat_subbursts <= stat_subbursts + 32'd1;
            if (state == ISSUE && fifo_full && stat_fifo_full_cycles != '1)
                stat_fifo_full_cycles <= stat_fifo_full_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// Directed bench for axi_rd_burst_splitter: vector table plus stall, back-pressure and reset sequences.
module tb_axi_rd_burst_splitter;
    localparam int AW = 64;
    localparam int DW = 512;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s_axi_arvalid, s_axi_arready;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic          s_axi_rvalid, s_axi_rready, s_axi_rlast;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          m_axi_arvalid, m_axi_arready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic          m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
`ifdef AXI_RD_SPLIT_STATS_EN
    logic [31:0]   stat_bursts, stat_subbursts, stat_fifo_full_cycles;
`endif

    always #5 aclk = ~aclk;

    axi_rd_burst_splitter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(64), .OUTSTANDING(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
`ifdef AXI_RD_SPLIT_STATS_EN
        ,
        .stat_bursts(stat_bursts), .stat_subbursts(stat_subbursts),
        .stat_fifo_full_cycles(stat_fifo_full_cycles)
`endif
    );

    typedef struct {
        logic [63:0]      addr;
        logic [7:0]       len;
        int               n_sub;
        logic [3:0][63:0] ea;
        logic [3:0][7:0]  el;
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0;
    int          fails = 0;
    logic [63:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    int          pend_q[$];
    int          up_tot_q[$];
    int          up_idx = 0;
    int          up_cnt = 0;
    int          up_beats = 0;
    logic [31:0] r_seq = 0;
    logic [31:0] exp_seq = 0;
    logic        r_en = 1'b1;
    logic        toggle = 1'b0;

    function automatic vec_t mk(input logic [63:0] a, input logic [7:0] l, input int n,
                                input logic [63:0] a0, input logic [7:0] l0,
                                input logic [63:0] a1, input logic [7:0] l1,
                                input logic [63:0] a2, input logic [7:0] l2,
                                input logic [63:0] a3, input logic [7:0] l3);
        vec_t v;
        v.addr = a; v.len = l; v.n_sub = n;
        v.ea[0] = a0; v.el[0] = l0; v.ea[1] = a1; v.el[1] = l1;
        v.ea[2] = a2; v.el[2] = l2; v.ea[3] = a3; v.el[3] = l3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Downstream slave: logs m_ar handshakes and returns beats numbered by r_seq.
    initial begin : r_drv
        int         bidx;
        bit         hs_r, hs_a;
        logic [7:0] a_len;
        bidx = 0; a_len = 0;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
        forever begin
            @(negedge aclk);
            hs_r = m_axi_rvalid && m_axi_rready;
            hs_a = m_axi_arvalid && m_axi_arready;
            if (hs_a) begin
                ar_addr_q.push_back(m_axi_araddr);
                ar_len_q.push_back(m_axi_arlen);
                a_len = m_axi_arlen;
            end
            @(posedge aclk); #1;
            if (!aresetn) begin
                pend_q.delete();
                bidx = 0;
            end else begin
                if (hs_a) pend_q.push_back(int'(a_len) + 1);
                if (hs_r) begin
                    r_seq++;
                    bidx++;
                    if (bidx == pend_q[0]) begin
                        void'(pend_q.pop_front());
                        bidx = 0;
                    end
                end
            end
            if (r_en && aresetn && pend_q.size() > 0) begin
                m_axi_rvalid = 1'b1;
                m_axi_rlast  = (bidx == pend_q[0] - 1);
                m_axi_rdata  = {16{r_seq}};
                m_axi_rresp  = r_seq[1:0];
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
            end
        end
    end

    initial begin : rready_drv
        s_axi_rready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            s_axi_rready = toggle ? ~s_axi_rready : 1'b1;
        end
    end

    // Upstream monitor: order, rresp, one rlast per parent burst, m_rready follows s_rready.
    initial begin : up_mon
        logic exp_last;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                up_idx = up_tot_q.size();
                up_cnt = 0;
            end else if (s_axi_rvalid) begin
                chk("m_rready_follow", m_axi_rready, s_axi_rready);
                if (s_axi_rready) begin
                    exp_last = (up_idx < up_tot_q.size()) && (up_cnt == up_tot_q[up_idx] - 1);
                    chk("beat_owned", up_idx < up_tot_q.size(), 1);
                    chk("rdata", s_axi_rdata == {16{exp_seq}}, 1);
                    chk("rresp", s_axi_rresp, exp_seq[1:0]);
                    chk("s_rlast", s_axi_rlast, exp_last);
                    exp_seq++;
                    up_cnt++;
                    up_beats++;
                    if (exp_last) begin
                        up_idx++;
                        up_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic [63:0] a, input logic [7:0] l);
        bit done;
        done = 0;
        s_axi_arvalid = 1'b1; s_axi_araddr = a; s_axi_arlen = l;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge aclk);
            if (s_axi_arready) begin
                done = 1;
                up_tot_q.push_back(int'(l) + 1);
            end
            @(posedge aclk); #1;
        end
        s_axi_arvalid = 1'b0;
        chk("ar_accept", done, 1);
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge aclk);
            if (up_idx == up_tot_q.size() && s_axi_arready && !m_axi_rvalid) ok = 1;
        end
        @(posedge aclk); #1;
        chk({nm, "_done"}, ok, 1);
    endtask

    task automatic check_subs(input vec_t v, input int base, input string nm);
        for (int j = 0; j < v.n_sub; j++) begin
            if (base + j < ar_addr_q.size()) begin
                chk($sformatf("%s_addr%0d", nm, j), ar_addr_q[base + j], v.ea[j]);
                chk($sformatf("%s_len%0d", nm, j), ar_len_q[base + j], v.el[j]);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int base;
        int b0;
        base = ar_addr_q.size();
        b0   = up_beats;
        issue(v.addr, v.len);
        wait_done(nm);
        chk({nm, "_nsub"}, ar_addr_q.size() - base, v.n_sub);
        chk({nm, "_beats"}, up_beats - b0, int'(v.len) + 1);
        check_subs(v, base, nm);
    endtask

    initial begin : main
        int base;
        int b0;
        bit seen;
        aresetn = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd6;
        m_axi_arready = 1'b1;

        vecs[0] = mk(64'h0000, 8'd15, 1, 64'h0000, 8'd15, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(64'h0FC0, 8'd3, 2, 64'h0FC0, 8'd0, 64'h1000, 8'd2, 0, 0, 0, 0);
        vecs[2] = mk(64'h0000, 8'd255, 4, 64'h0000, 8'd63, 64'h1000, 8'd63,
                     64'h2000, 8'd63, 64'h3000, 8'd63);
        vecs[3] = mk(64'h1FE5, 8'd7, 2, 64'h1FC0, 8'd0, 64'h2000, 8'd6, 0, 0, 0, 0);
        vecs[4] = mk(64'h0800, 8'd63, 2, 64'h0800, 8'd31, 64'h1000, 8'd31, 0, 0, 0, 0);
        vecs[5] = mk(64'h0040, 8'd0, 1, 64'h0040, 8'd0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_arready", s_axi_arready, 0);
        chk("rst_m_arvalid", m_axi_arvalid, 0);
        chk("rst_m_araddr", m_axi_araddr, 0);
        chk("rst_m_arlen", m_axi_arlen, 0);
        chk("rst_m_arsize", m_axi_arsize, 6);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("idle_s_arready", s_axi_arready, 1);
        @(posedge aclk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // FIFO of two sub-bursts fills and holds off the third request.
        r_en = 1'b0;
        base = ar_addr_q.size();
        issue(vecs[2].addr, vecs[2].len);
        repeat (8) @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("t4_two_issued", ar_addr_q.size() - base, 2);
        chk("t4_stalled", m_axi_arvalid, 0);
        @(posedge aclk); #1;
        r_en = 1'b1;
        seen = 0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge aclk);
            if (m_axi_rvalid && m_axi_rready && m_axi_rlast) seen = 1;
        end
        chk("t4_pop_seen", seen, 1);
        chk("t4_hold_before_pop", m_axi_arvalid, 0);
        @(negedge aclk);
        chk("t4_rise_after_pop", m_axi_arvalid, 1);
        @(posedge aclk); #1;
        wait_done("t4");
        chk("t4_nsub", ar_addr_q.size() - base, 4);
        check_subs(vecs[2], base, "t4");

        // Back-to-back bursts with 50% upstream back-pressure.
        toggle = 1'b1;
        base = ar_addr_q.size();
        b0 = up_beats;
        issue(vecs[1].addr, vecs[1].len);
        issue(vecs[4].addr, vecs[4].len);
        wait_done("t5");
        toggle = 1'b0;
        chk("t5_beats", up_beats - b0, 68);
        chk("t5_nsub", ar_addr_q.size() - base, 4);
        check_subs(vecs[1], base, "t5a");
        check_subs(vecs[4], base + 2, "t5b");

        // Reset while the first sub-burst request is pending.
        r_en = 1'b0;
        issue(vecs[2].addr, vecs[2].len);
        #2;
        chk("t6_pre_arvalid", m_axi_arvalid, 1);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_arvalid", m_axi_arvalid, 0);
        chk("t6_rst_arready", s_axi_arready, 0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        r_en = 1'b1;
        @(posedge aclk); #1;
        run_vec(vecs[0], "t6_vec0");
`ifdef AXI_RD_SPLIT_STATS_EN
        chk("t6_stat_bursts", stat_bursts, 1);
        chk("t6_stat_subbursts", stat_subbursts, 1);
        chk("t6_stat_full", stat_fifo_full_cycles, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
